// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout sequencer.
// Provides the FSM state enum and the index-width helper.
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        STREAM,
        DONE
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/readout_row_buffer.sv
// W x 8-bit row capture register with a column read mux.
// Ports: clk, rst_n, load, data_in (W*8), col (CW), pix (8).
module readout_row_buffer #(
    parameter int WIDTH = 2,
    parameter int CW    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH*8-1:0] data_in,
    input  logic [CW-1:0]      col,
    output logic [7:0]         pix
);

    logic [WIDTH*8-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (load) begin
            row_q <= data_in;
        end
    end

    // Explicit compare per lane so a col outside 0..W-1 reads zero.
    always_comb begin
        pix = '0;
        for (int c = 0; c < WIDTH; c++) begin
            if (col == CW'(c)) begin
                pix = row_q[c*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Readout sequencer: selects rows, captures them and streams pixels.
// Ports: CLK, RESET_N, START, READ, DATA_OUT, PIX_* stream, BUSY, FRAME_DONE.
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int READ_SETTLE        = 2
) (
    input  logic                                   CLK,
    input  logic                                   RESET_N,
    input  logic                                   START,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]          READ,
    input  logic [PIXEL_ARRAY_WIDTH*8-1:0]         DATA_OUT,
    output logic [7:0]                             PIX_DATA,
    output logic [idx_w(PIXEL_ARRAY_HEIGHT)-1:0]   PIX_ROW,
    output logic [idx_w(PIXEL_ARRAY_WIDTH)-1:0]    PIX_COL,
    output logic                                   PIX_LAST,
    output logic                                   PIX_VALID,
    input  logic                                   PIX_READY,
    output logic                                   BUSY,
    output logic                                   FRAME_DONE
);

    localparam int H  = PIXEL_ARRAY_HEIGHT;
    localparam int W  = PIXEL_ARRAY_WIDTH;
    localparam int RW = idx_w(H);
    localparam int CW = idx_w(W);
    localparam int SW = idx_w(READ_SETTLE);

    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [SW-1:0] SET_MAX = SW'(READ_SETTLE - 1);

    state_t        state, state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [SW-1:0] settle;
    logic          settled, fire, row_end, col_end, load;

    assign settled = (settle == SET_MAX);
    assign row_end = (row == ROW_MAX);
    assign col_end = (col == COL_MAX);
    assign fire    = PIX_VALID & PIX_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        PIX_VALID  = 1'b0;
        BUSY       = 1'b0;
        FRAME_DONE = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) state_nxt = SELECT;
            end
            SELECT: begin
                BUSY = 1'b1;
                if (settled) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                BUSY      = 1'b1;
                load      = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                BUSY      = 1'b1;
                PIX_VALID = 1'b1;
                if (fire && col_end) begin
                    state_nxt = row_end ? DONE : SELECT;
                end
            end
            DONE: begin
                FRAME_DONE = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle count returns to zero on its last SELECT cycle, so every
    // SELECT entry starts from zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row    <= '0;
            col    <= '0;
            settle <= '0;
        end else begin
            if (state == SELECT) begin
                settle <= settled ? '0 : settle + SW'(1);
            end
            if (state == IDLE && START) begin
                row <= '0;
            end
            if (load) begin
                col <= '0;
            end
            if (state == STREAM && fire) begin
                if (!col_end) begin
                    col <= col + CW'(1);
                end else if (!row_end) begin
                    row <= row + RW'(1);
                end
            end
        end
    end

    // Row select is held through SELECT and CAPTURE only.
    always_comb begin
        READ = '0;
        if (state == SELECT || state == CAPTURE) begin
            for (int r = 0; r < H; r++) begin
                READ[r] = (row == RW'(r));
            end
        end
    end

    readout_row_buffer #(
        .WIDTH (W),
        .CW    (CW)
    ) u_row_buffer (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .load    (load),
        .data_in (DATA_OUT),
        .col     (col),
        .pix     (PIX_DATA)
    );

    assign PIX_ROW  = row;
    assign PIX_COL  = col;
    assign PIX_LAST = PIX_VALID & row_end & col_end;

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: three configurations
// (2x2/settle 2, 3x4/settle 3, 1x1/settle 2) against a frame model.
module tb_pixel_readout;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [3][4];
    logic [7:0] gar;

    int hs  [3] = '{2, 3, 1};
    int ws  [3] = '{2, 4, 1};
    int rss [3] = '{2, 3, 2};

    always #5 clk = ~clk;

    always @(negedge clk) gar <= 8'($urandom);

    logic st_a, st_b, st_c;
    assign st_a = start && (sel == 0);
    assign st_b = start && (sel == 1);
    assign st_c = start && (sel == 2);

    // Config A: 2x2, settle 2
    logic [1:0]  read_a;
    logic [15:0] do_a;
    logic [7:0]  pd_a;
    logic        pr_a, pc_a, pl_a, pv_a, bz_a, fd_a;

    // Config B: 3 rows x 4 cols, settle 3
    logic [2:0]  read_b;
    logic [31:0] do_b;
    logic [7:0]  pd_b;
    logic [1:0]  pr_b, pc_b;
    logic        pl_b, pv_b, bz_b, fd_b;

    // Config C: 1x1, settle 2
    logic [0:0]  read_c;
    logic [7:0]  do_c;
    logic [7:0]  pd_c;
    logic        pr_c, pc_c, pl_c, pv_c, bz_c, fd_c;

    // Pixel array model: selected row drives mem, otherwise noise.
    always_comb begin
        do_a = {2{gar}};
        for (int r = 0; r < 2; r++)
            if (read_a == 2'(1 << r))
                for (int c = 0; c < 2; c++) do_a[c*8 +: 8] = mem[r][c];
    end

    always_comb begin
        do_b = {4{gar}};
        for (int r = 0; r < 3; r++)
            if (read_b == 3'(1 << r))
                for (int c = 0; c < 4; c++) do_b[c*8 +: 8] = mem[r][c];
    end

    always_comb begin
        do_c = gar;
        if (read_c == 1'b1) do_c = mem[0][0];
    end

    pixel_readout u_a (
        .CLK(clk), .RESET_N(rst_n), .START(st_a), .READ(read_a),
        .DATA_OUT(do_a), .PIX_DATA(pd_a), .PIX_ROW(pr_a), .PIX_COL(pc_a),
        .PIX_LAST(pl_a), .PIX_VALID(pv_a), .PIX_READY(ready),
        .BUSY(bz_a), .FRAME_DONE(fd_a)
    );

    pixel_readout #(
        .PIXEL_ARRAY_HEIGHT(3), .PIXEL_ARRAY_WIDTH(4), .READ_SETTLE(3)
    ) u_b (
        .CLK(clk), .RESET_N(rst_n), .START(st_b), .READ(read_b),
        .DATA_OUT(do_b), .PIX_DATA(pd_b), .PIX_ROW(pr_b), .PIX_COL(pc_b),
        .PIX_LAST(pl_b), .PIX_VALID(pv_b), .PIX_READY(ready),
        .BUSY(bz_b), .FRAME_DONE(fd_b)
    );

    pixel_readout #(
        .PIXEL_ARRAY_HEIGHT(1), .PIXEL_ARRAY_WIDTH(1), .READ_SETTLE(2)
    ) u_c (
        .CLK(clk), .RESET_N(rst_n), .START(st_c), .READ(read_c),
        .DATA_OUT(do_c), .PIX_DATA(pd_c), .PIX_ROW(pr_c), .PIX_COL(pc_c),
        .PIX_LAST(pl_c), .PIX_VALID(pv_c), .PIX_READY(ready),
        .BUSY(bz_c), .FRAME_DONE(fd_c)
    );

    int   o_read, o_data, o_row, o_col;
    logic o_valid, o_last, o_busy, o_done;

    always_comb begin
        o_read = 0; o_data = 0; o_row = 0; o_col = 0;
        o_valid = 1'b0; o_last = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        case (sel)
            0: begin
                o_read = 32'(read_a); o_data = 32'(pd_a);
                o_row = 32'(pr_a); o_col = 32'(pc_a);
                o_valid = pv_a; o_last = pl_a; o_busy = bz_a; o_done = fd_a;
            end
            1: begin
                o_read = 32'(read_b); o_data = 32'(pd_b);
                o_row = 32'(pr_b); o_col = 32'(pc_b);
                o_valid = pv_b; o_last = pl_b; o_busy = bz_b; o_done = fd_b;
            end
            default: begin
                o_read = 32'(read_c); o_data = 32'(pd_c);
                o_row = 32'(pr_c); o_col = 32'(pc_c);
                o_valid = pv_c; o_last = pl_c; o_busy = bz_c; o_done = fd_c;
            end
        endcase
    end

    // One frame on config s. mode 0: READY=1; 1: READY 1,0,0,1;
    // 2: random READY; 3: random READY plus stray START pulses.
    task automatic run_frame(input int s, input int mode, input bit preset);
        int h, w, rs, total, k, nv, first, last_hs, run, er, n_done, p;
        bit rdy, ev, eb, ed;
        int pat [4] = '{1, 0, 0, 1};
        h = hs[s]; w = ws[s]; rs = rss[s]; total = h * w;
        if (!preset)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) mem[r][c] = 8'($urandom);
        sel = s;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0; nv = rs + 2; first = -1; last_hs = -1;
        run = 0; er = 0; n_done = 0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (k == total && cyc > last_hs + 3) break;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = pat[(cyc - 1) % 4] != 0;
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            ready = rdy;
            start = (mode == 3 && k < total && $urandom_range(0, 2) == 0);
            ev = (k < total && cyc >= nv);
            eb = (k < total);
            ed = (k == total && cyc == last_hs + 1);
            checks++;
            if (o_valid !== ev)
                $display("FAIL valid s=%0d cyc=%0d got=%b exp=%b", s, cyc, o_valid, ev);
            if (o_valid && first < 0) first = cyc;
            if (ev) begin
                p = 32'(mem[k / w][k % w]);
                checks++;
                if (o_data !== p) begin
                    errors++;
                    $display("FAIL data s=%0d k=%0d got=%0h exp=%0h", s, k, o_data, p);
                end
                checks++;
                if (o_row !== k / w || o_col !== k % w) begin
                    errors++;
                    $display("FAIL index s=%0d k=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             s, k, o_row, o_col, k / w, k % w);
                end
                checks++;
                if (o_last !== (k == total - 1)) begin
                    errors++;
                    $display("FAIL last s=%0d k=%0d got=%b", s, k, o_last);
                end
            end
            if (o_valid !== ev) errors++;
            checks++;
            if (o_busy !== eb) begin
                errors++;
                $display("FAIL busy s=%0d cyc=%0d got=%b exp=%b", s, cyc, o_busy, eb);
            end
            checks++;
            if (o_done !== ed) begin
                errors++;
                $display("FAIL done s=%0d cyc=%0d got=%b exp=%b", s, cyc, o_done, ed);
            end
            if (o_done) n_done++;
            if (o_read != 0) begin
                checks++;
                if (o_read !== (1 << er) || o_valid) begin
                    errors++;
                    $display("FAIL read s=%0d cyc=%0d got=%0h exp=%0h", s, cyc, o_read, 1 << er);
                end
                run++;
            end else if (run > 0) begin
                checks++;
                if (run != rs + 1) begin
                    errors++;
                    $display("FAIL read_len s=%0d row=%0d got=%0d exp=%0d", s, er, run, rs + 1);
                end
                run = 0;
                er++;
            end
            if (ev && rdy) begin
                k++;
                if (k == total) last_hs = cyc;
                else if (k % w == 0) nv = cyc + rs + 2;
                else nv = cyc + 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        checks++;
        if (k != total) begin
            errors++;
            $display("FAIL count s=%0d got=%0d exp=%0d", s, k, total);
        end
        checks++;
        if (first != rs + 2) begin
            errors++;
            $display("FAIL latency s=%0d got=%0d exp=%0d", s, first, rs + 2);
        end
        checks++;
        if (n_done != 1 || er != h) begin
            errors++;
            $display("FAIL frame s=%0d done=%0d rows=%0d exp=1,%0d", s, n_done, er, h);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (o_read !== 0) begin
                errors++;
                $display("FAIL reset_read s=%0d got=%0h exp=0", s, o_read);
            end
            checks++;
            if ({o_valid, o_last, o_busy, o_done} !== 4'b0) begin
                errors++;
                $display("FAIL reset_flags s=%0d got=%b exp=0000", s,
                         {o_valid, o_last, o_busy, o_done});
            end
            checks++;
            if (o_data !== 0 || o_row !== 0 || o_col !== 0) begin
                errors++;
                $display("FAIL reset_fields s=%0d got=%0h/%0d/%0d exp=0", s,
                         o_data, o_row, o_col);
            end
        end
    endtask

    task automatic test_basic();
        mem[0][0] = 8'h11; mem[0][1] = 8'h22;
        mem[1][0] = 8'h33; mem[1][1] = 8'h44;
        run_frame(0, 0, 1'b1);
    endtask

    task automatic test_stall();
        run_frame(0, 1, 1'b0);
        run_frame(0, 2, 1'b0);
        run_frame(0, 2, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame(0, 3, 1'b0);
        run_frame(0, 3, 1'b0);
    endtask

    task automatic test_abort();
        int n;
        bit hit;
        sel = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) mem[r][c] = 8'($urandom);
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (o_valid && o_row == 1) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach got=timeout exp=row1 stream");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_read !== 0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_now got=read %0h valid %b busy %b exp=0",
                     o_read, o_valid, o_busy);
        end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_done || o_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL abort_quiet got=%0d exp=0", n);
        end
        run_frame(0, 0, 1'b0);
    endtask

    task automatic test_large();
        run_frame(1, 0, 1'b0);
        run_frame(1, 2, 1'b0);
        run_frame(1, 3, 1'b0);
    endtask

    task automatic test_single();
        mem[0][0] = 8'hA5;
        run_frame(2, 0, 1'b1);
        run_frame(2, 1, 1'b0);
        run_frame(2, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_abort();
        test_large();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
